// File: rtl/core_launcher.sv
// core_launcher: host-side sequencer that loads an operand image into data
// memory with the core held in reset, runs the core until it reports done or
// the cycle budget runs out, then halts it and reports status to the host.
module core_launcher #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          dm_wr_en,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wr_data,
    output logic          core_rst,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PRIME = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_TMO   = 3'd5;

    localparam logic [CW-1:0] CYC_LIMIT = CW'(TIMEOUT);
    localparam logic [AW-1:0] PTR_LAST  = '1;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_nx;
    logic [CW-1:0] cycles_nx;
    logic          hs;
    logic          wr_en_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] data_nx;

    // Next-state, write-pointer, write-port and run-counter decode
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        cycles_nx = cycles;
        wr_en_nx  = 1'b0;
        addr_nx   = dm_addr;
        data_nx   = dm_wr_data;
        hs        = ld_valid & ld_ready;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_LOAD;
                    ptr_nx    = '0;
                    cycles_nx = '0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wr_en_nx = 1'b1;
                    addr_nx  = ptr;
                    data_nx  = ld_data;
                    ptr_nx   = ptr + AW'(1);
                    // Image ends on the tagged byte or when memory is full
                    if (ld_last || (ptr == PTR_LAST)) begin
                        state_nx = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                cycles_nx = cycles + CW'(1);
                // core_done takes priority over an expiring budget
                if (core_done) begin
                    state_nx = S_DONE;
                end else if (cycles_nx == CYC_LIMIT) begin
                    state_nx = S_TMO;
                end
            end
            S_DONE, S_TMO: begin
                if (!start) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cycles     <= '0;
            dm_wr_en   <= 1'b0;
            dm_addr    <= '0;
            dm_wr_data <= '0;
            ld_ready   <= 1'b0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            cycles     <= cycles_nx;
            dm_wr_en   <= wr_en_nx;
            dm_addr    <= addr_nx;
            dm_wr_data <= data_nx;
            ld_ready   <= (state_nx == S_LOAD);
            core_rst   <= (state_nx != S_RUN);
            busy       <= (state_nx == S_LOAD) || (state_nx == S_PRIME) || (state_nx == S_RUN);
            finished   <= (state_nx == S_DONE) || (state_nx == S_TMO);
            timed_out  <= (state_nx == S_TMO);
        end
    end

endmodule
